// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, word-length encodings and
// the line-control helper functions used by both serial paths.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   localparam logic [1:0] WLS_5 = 2'b00;
   localparam logic [1:0] WLS_6 = 2'b01;
   localparam logic [1:0] WLS_7 = 2'b10;
   localparam logic [1:0] WLS_8 = 2'b11;

   function automatic logic [3:0] wls_to_len(input logic [1:0] wls);
      return 4'd5 + {2'b00, wls};
   endfunction

   // Unused upper data bits must be zero so they do not disturb the XOR.
   function automatic logic parity_expected(input logic [7:0] data,
                                            input logic       eps,
                                            input logic       sp);
      logic par;
      if (sp)
         par = ~eps;
      else if (eps)
         par = ^data;
      else
         par = ~^data;
      return par;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 16550-style serial receive engine: oversampled start detection, centre
// sampling of data/parity/stop bits and a one-cycle push to the receive FIFO.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_pulse,
   input  logic       rx,
   input  logic [1:0] wls,
   input  logic       pen,
   input  logic       eps,
   input  logic       sp,
   output logic [7:0] rx_data,
   output logic       rx_push,
   output logic       pe,
   output logic       fe,
   output logic       bi,
   output logic       rx_busy
);

   localparam int OSW = $clog2(OVERSAMPLE);
   localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);
   localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);

   logic           rx_p0;
   logic           rx_s;
   logic           baud_q;
   logic           tick;
   rx_state_e      state;
   rx_state_e      state_nx;
   logic [OSW-1:0] os_cnt;
   logic [2:0]     bit_cnt;
   logic [7:0]     shreg;
   logic           par_bit;
   logic [1:0]     wls_f;
   logic           pen_f;
   logic           eps_f;
   logic           sp_f;
   logic           go_start;
   logic           os_clr;
   logic           samp_data;
   logic           samp_par;
   logic           samp_stop;
   logic           last_bit;

   // Stage 0: input synchronizer and baud strobe edge detect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_p0  <= 1'b1;
         rx_s   <= 1'b1;
         baud_q <= 1'b0;
      end else begin
         rx_p0  <= rx;
         rx_s   <= rx_p0;
         baud_q <= baud_pulse;
      end
   end

   // Only the first cycle of a stretched strobe counts.
   assign tick     = baud_pulse & ~baud_q;
   assign last_bit = ({1'b0, bit_cnt} == (wls_to_len(wls_f) - 4'd1));

   // Stage 1: frame sequencing
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      go_start  = 1'b0;
      os_clr    = 1'b0;
      samp_data = 1'b0;
      samp_par  = 1'b0;
      samp_stop = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rx_s) begin
               state_nx = ST_START;
               go_start = 1'b1;
            end
         end
         ST_START: begin
            if (tick && os_cnt == OS_HALF) begin
               os_clr   = 1'b1;
               state_nx = rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick && os_cnt == OS_LAST) begin
               samp_data = 1'b1;
               if (last_bit)
                  state_nx = pen_f ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (tick && os_cnt == OS_LAST) begin
               samp_par = 1'b1;
               state_nx = ST_STOP;
            end
         end
         ST_STOP: begin
            if (tick && os_cnt == OS_LAST) begin
               samp_stop = 1'b1;
               state_nx  = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         os_cnt  <= '0;
         bit_cnt <= 3'd0;
      end else begin
         if (go_start || os_clr)
            os_cnt <= '0;
         else if (tick && state != ST_IDLE)
            os_cnt <= os_cnt + 1'b1;
         if (os_clr)
            bit_cnt <= 3'd0;
         else if (samp_data)
            bit_cnt <= bit_cnt + 3'd1;
      end
   end

   // Frame datapath; cleared at every start so unused data bits read 0.
   always_ff @(posedge clk) begin
      if (go_start) begin
         shreg   <= 8'h00;
         par_bit <= 1'b0;
         wls_f   <= wls;
         pen_f   <= pen;
         eps_f   <= eps;
         sp_f    <= sp;
      end else begin
         if (samp_data)
            shreg[bit_cnt] <= rx_s;
         if (samp_par)
            par_bit <= rx_s;
      end
   end

   // Stage 2: registered push to the receive FIFO
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_push <= 1'b0;
         rx_data <= 8'h00;
         pe      <= 1'b0;
         fe      <= 1'b0;
         bi      <= 1'b0;
      end else begin
         rx_push <= samp_stop;
         if (samp_stop) begin
            rx_data <= shreg;
            pe      <= pen_f & (par_bit != parity_expected(shreg, eps_f, sp_f));
            fe      <= ~rx_s;
            bi      <= ~rx_s & ~(|shreg) & (~par_bit | ~pen_f);
         end
      end
   end

   assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: framed characters, parity variants,
// framing/break, glitch rejection, mid-frame LCR change and mid-frame reset.
module tb_uart_rx_core;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       baud_pulse = 1'b0;
   logic       rx = 1'b1;
   logic [1:0] wls = 2'b11;
   logic       pen = 1'b0;
   logic       eps = 1'b0;
   logic       sp = 1'b0;
   logic [7:0] rx_data;
   logic       rx_push;
   logic       pe;
   logic       fe;
   logic       bi;
   logic       rx_busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t_start  = 0;
   logic [10:0] pq[$];
   int          tq[$];

   uart_rx_core #(.OVERSAMPLE(16)) dut (
      .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .rx(rx),
      .wls(wls), .pen(pen), .eps(eps), .sp(sp),
      .rx_data(rx_data), .rx_push(rx_push), .pe(pe), .fe(fe), .bi(bi),
      .rx_busy(rx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      forever begin
         repeat (3) @(negedge clk);
         baud_pulse = 1'b1;
         @(negedge clk);
         baud_pulse = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rx_push) begin
         pq.push_back({bi, fe, pe, rx_data});
         tq.push_back(cyc);
      end
   end

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL watchdog: cycles %0d exceeded limit %0d", cyc, 60000);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input int nb, input logic hp,
                             input logic pb, input logic sb);
      @(negedge clk);
      t_start = cyc;
      rx = 1'b0;
      repeat (64) @(negedge clk);
      for (int i = 0; i < nb; i++) begin
         rx = d[i];
         repeat (64) @(negedge clk);
      end
      if (hp) begin
         rx = pb;
         repeat (64) @(negedge clk);
      end
      rx = sb;
      // A low stop bit is released early so it cannot look like a new start.
      if (sb) begin
         repeat (64) @(negedge clk);
      end else begin
         repeat (40) @(negedge clk);
         rx = 1'b1;
         repeat (24) @(negedge clk);
      end
      rx = 1'b1;
      repeat (64) @(negedge clk);
   endtask

   task automatic take_push(input string tag, input logic [7:0] d, input logic epe,
                            input logic efe, input logic ebi);
      logic [10:0] p;
      check({tag, "_present"}, 32'(pq.size() > 0), 32'd1);
      if (pq.size() > 0) begin
         p = pq.pop_front();
         void'(tq.pop_front());
         check({tag, "_data"}, 32'(p[7:0]), 32'(d));
         check({tag, "_pe"}, 32'(p[8]), 32'(epe));
         check({tag, "_fe"}, 32'(p[9]), 32'(efe));
         check({tag, "_bi"}, 32'(p[10]), 32'(ebi));
      end
   endtask

   initial begin
      int t_push;
      repeat (3) @(negedge clk);
      check("rst_data", 32'(rx_data), 32'h0);
      check("rst_push", 32'(rx_push), 32'h0);
      check("rst_pe", 32'(pe), 32'h0);
      check("rst_fe", 32'(fe), 32'h0);
      check("rst_bi", 32'(bi), 32'h0);
      check("rst_busy", 32'(rx_busy), 32'h0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // 8N1 0xA5, push roughly 9.5 bit times after the start edge
      wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
      check("a5_count", 32'(pq.size()), 32'd1);
      t_push = (tq.size() > 0) ? tq[0] - t_start : 0;
      check("a5_latency", 32'(t_push >= 600 && t_push <= 625), 32'd1);
      take_push("a5", 8'hA5, 1'b0, 1'b0, 1'b0);
      check("a5_idle", 32'(rx_busy), 32'h0);

      // 5-bit odd parity
      wls = 2'b00; pen = 1'b1; eps = 1'b0; sp = 1'b0;
      send_frame(8'h10, 5, 1'b1, 1'b0, 1'b1);
      check("odd_ok_count", 32'(pq.size()), 32'd1);
      take_push("odd_ok", 8'h10, 1'b0, 1'b0, 1'b0);
      send_frame(8'h10, 5, 1'b1, 1'b1, 1'b1);
      check("odd_bad_count", 32'(pq.size()), 32'd1);
      take_push("odd_bad", 8'h10, 1'b1, 1'b0, 1'b0);

      // 7-bit stick parity, expected parity bit 0
      wls = 2'b10; pen = 1'b1; eps = 1'b1; sp = 1'b1;
      send_frame(8'h7F, 7, 1'b1, 1'b1, 1'b1);
      check("stick_bad_count", 32'(pq.size()), 32'd1);
      take_push("stick_bad", 8'h7F, 1'b1, 1'b0, 1'b0);
      send_frame(8'h7F, 7, 1'b1, 1'b0, 1'b1);
      check("stick_ok_count", 32'(pq.size()), 32'd1);
      take_push("stick_ok", 8'h7F, 1'b0, 1'b0, 1'b0);

      // Framing error, then a two-frame break
      wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
      check("fe_count", 32'(pq.size()), 32'd1);
      take_push("fe", 8'h3C, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      rx = 1'b0;
      repeat (1240) @(negedge clk);
      rx = 1'b1;
      repeat (640) @(negedge clk);
      check("brk_count", 32'(pq.size()), 32'd2);
      take_push("brk1", 8'h00, 1'b0, 1'b1, 1'b1);
      take_push("brk2", 8'h00, 1'b0, 1'b1, 1'b1);
      check("brk_idle", 32'(rx_busy), 32'h0);

      // Short glitch is a false start
      @(negedge clk);
      rx = 1'b0;
      repeat (10) @(negedge clk);
      check("glitch_busy", 32'(rx_busy), 32'h1);
      repeat (10) @(negedge clk);
      rx = 1'b1;
      for (int k = 0; k < 40 && rx_busy; k++) @(negedge clk);
      check("glitch_idle", 32'(rx_busy), 32'h0);
      repeat (64) @(negedge clk);
      check("glitch_nopush", 32'(pq.size()), 32'd0);

      // Word length changed mid-frame keeps the latched 8-bit length
      wls = 2'b11;
      fork
         send_frame(8'h96, 8, 1'b0, 1'b0, 1'b1);
         begin
            repeat (200) @(negedge clk);
            wls = 2'b00;
         end
      join
      check("lcr_count", 32'(pq.size()), 32'd1);
      take_push("lcr", 8'h96, 1'b0, 1'b0, 1'b0);

      // Reset during data bit 3
      wls = 2'b11;
      @(negedge clk);
      rx = 1'b0;
      repeat (64) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = 1'b1;
         repeat (64) @(negedge clk);
      end
      rx = 1'b0;
      repeat (32) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mrst_busy", 32'(rx_busy), 32'h0);
      check("mrst_data", 32'(rx_data), 32'h0);
      check("mrst_push", 32'(rx_push), 32'h0);
      check("mrst_flags", 32'({pe, fe, bi}), 32'h0);
      repeat (4) @(negedge clk);
      rx = 1'b1;
      rst = 1'b0;
      repeat (64) @(negedge clk);
      check("mrst_nopush", 32'(pq.size()), 32'd0);
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
      check("post_rst_count", 32'(pq.size()), 32'd1);
      take_push("post_rst", 8'h5A, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
